// File: rtl/cache_line_fill.sv
// cache_line_fill: fetches one cache line over an AXI4 read burst and streams
// each returned beat into the line RAM of the selected victim way.
//
// Ports
//   axis_aclk, mod_rstn             clock, async active-low reset
//   fill_req_valid/ready/addr/way   fill request (miss address, victim way)
//   m_axi_ar*                       AXI4 read-address channel (master)
//   m_axi_r*                        AXI4 read-data channel (master)
//   ram_we/way/beat/wdata           registered line-RAM write port
//   fill_done, fill_err             one-cycle completion pulse and its status
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new fill request
// ADDR  | AR burst presented, waiting for arready
// DATA  | accepting R beats; after rlast, one extra cycle drains the RAM write
// DONE  | fill_done pulse, fill_err reports the sticky error flag
module cache_line_fill #(
  parameter int ADDR_WIDTH         = 48,
  parameter int BACKEND_DATA_WIDTH = 512,
  parameter int BACKEND_ID_WIDTH   = 1,
  parameter int CACHE_SIZE         = 512,
  parameter int CACHE_WAY          = 4,
  localparam int BEATS  = CACHE_SIZE * 8 / BACKEND_DATA_WIDTH,
  localparam int WAY_W  = $clog2(CACHE_WAY),
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic                          axis_aclk,
  input  logic                          mod_rstn,
  input  logic                          fill_req_valid,
  output logic                          fill_req_ready,
  input  logic [ADDR_WIDTH-1:0]         fill_req_addr,
  input  logic [WAY_W-1:0]              fill_req_way,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [BACKEND_ID_WIDTH-1:0]   m_axi_arid,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [BACKEND_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic [BACKEND_ID_WIDTH-1:0]   m_axi_rid,
  output logic                          ram_we,
  output logic [WAY_W-1:0]              ram_way,
  output logic [BEAT_W-1:0]             ram_beat,
  output logic [BACKEND_DATA_WIDTH-1:0] ram_wdata,
  output logic                          fill_done,
  output logic                          fill_err
);

  localparam int LINE_W   = $clog2(CACHE_SIZE);
  localparam int SIZE_ENC = $clog2(BACKEND_DATA_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [WAY_W-1:0]                way_q;
  logic [BEAT_W-1:0]               beat_q;
  logic                            full_q;
  logic                            last_q;
  logic                            err_q;
  logic                            ram_we_q;
  logic [WAY_W-1:0]                ram_way_q;
  logic [BEAT_W-1:0]               ram_beat_q;
  logic [BACKEND_DATA_WIDTH-1:0]   ram_wdata_q;

  logic req_hs;
  logic beat_acc;
  logic beat_bad;
  logic unused_bits;

  // rid is not checked and the in-line offset bits never reach the bus
  assign unused_bits = ^{m_axi_rid, addr_q[LINE_W-1:0]};

  // ready is gated by reset so it reads 0 while mod_rstn is held low
  assign fill_req_ready = (state_q == S_IDLE) && mod_rstn;
  assign req_hs         = fill_req_valid && fill_req_ready;

  // once rlast has been taken, rready drops for the drain cycle
  assign m_axi_rready = (state_q == S_DATA) && !last_q;
  assign beat_acc     = m_axi_rready && m_axi_rvalid;
  assign beat_bad     = (m_axi_rresp != 2'b00)
                     || ( m_axi_rlast && (beat_q != LAST_BEAT))
                     || (!m_axi_rlast && (beat_q == LAST_BEAT));

  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_araddr  = {addr_q[ADDR_WIDTH-1:LINE_W], {LINE_W{1'b0}}};
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(SIZE_ENC);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = '0;

  assign ram_we    = ram_we_q;
  assign ram_way   = ram_way_q;
  assign ram_beat  = ram_beat_q;
  assign ram_wdata = ram_wdata_q;

  assign fill_done = (state_q == S_DONE);
  assign fill_err  = (state_q == S_DONE) && err_q;

  always_ff @(posedge axis_aclk or negedge mod_rstn) begin
    if (!mod_rstn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_hs) state_d = S_ADDR;
      S_ADDR:  if (m_axi_arready) state_d = S_DATA;
      S_DATA:  if (last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge mod_rstn) begin
    if (!mod_rstn) begin
      addr_q      <= '0;
      way_q       <= '0;
      beat_q      <= '0;
      full_q      <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_way_q   <= '0;
      ram_beat_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      if (req_hs) begin
        addr_q <= fill_req_addr;
        way_q  <= fill_req_way;
        err_q  <= 1'b0;
      end
      if ((state_q == S_ADDR) && m_axi_arready) begin
        beat_q <= '0;
        full_q <= 1'b0;
        last_q <= 1'b0;
      end
      if (beat_acc) begin
        if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_W'(1);
        // the last slot of the line is now taken; later beats are dropped
        if (beat_q == LAST_BEAT) full_q <= 1'b1;
        if (m_axi_rlast) last_q <= 1'b1;
        if (beat_bad) err_q <= 1'b1;
        ram_way_q   <= way_q;
        ram_beat_q  <= beat_q;
        ram_wdata_q <= m_axi_rdata;
      end
      ram_we_q <= beat_acc && !full_q;
    end
  end

endmodule
